// File: rtl/tdma_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdma_pkg : shared types, default constants and index-width helper for TDMA
// Revision : 1.0
// ---------------------------------------------------------------------------
package tdma_pkg;

  typedef enum logic [0:0] {
    DISABLED = 1'b0,
    RUN      = 1'b1
  } tdma_state_t;

  localparam int DEF_NUM_SLOTS   = 8;
  localparam int DEF_SLOT_CYCLES = 16;

  // Width of an index counting 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdma_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdma_sync_fifo : single-clock word FIFO with push/pop/full/empty/count
// Revision : 1.0
// ---------------------------------------------------------------------------
module tdma_sync_fifo
  import tdma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = idx_width(DEPTH);
  localparam int NW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == NW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop frees the slot the simultaneous push needs, so full+pop accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/tdma_send_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdma_send_scheduler : buffers processor words, releases one per frame in MY_SLOT
// Revision : 1.0
// ---------------------------------------------------------------------------
module tdma_send_scheduler
  import tdma_pkg::*;
#(
  parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int MY_SLOT     = 0,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              sched_en,
  input  logic [DATA_W-1:0]                 send_data,
  input  logic                              send_valid,
  output logic                              send_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              overflow,
  input  logic                              overflow_clr,
  output logic [DATA_W-1:0]                 tdma_out,
  output logic                              tdma_out_valid,
  output logic [idx_width(NUM_SLOTS)-1:0]   slot_cnt,
  output logic                              frame_start
);

  localparam int SW = idx_width(NUM_SLOTS);
  localparam int CW = idx_width(SLOT_CYCLES);

  tdma_state_t       state;
  tdma_state_t       state_nxt;
  logic [CW-1:0]     cycle_cnt;
  logic [CW-1:0]     cycle_nxt;
  logic [SW-1:0]     slot_nxt;
  logic              pop;
  logic              push;
  logic              drop;
  logic              frame_nxt;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= DISABLED;
    else          state <= state_nxt;
  end

  // Counters advance only while already running; the enabling edge lands on (0,0).
  always_comb begin
    state_nxt = state;
    cycle_nxt = '0;
    slot_nxt  = '0;
    case (state)
      DISABLED: begin
        if (sched_en) state_nxt = RUN;
      end
      RUN: begin
        if (!sched_en) begin
          state_nxt = DISABLED;
        end else if (cycle_cnt == CW'(SLOT_CYCLES - 1)) begin
          cycle_nxt = '0;
          slot_nxt  = (slot_cnt == SW'(NUM_SLOTS - 1)) ? '0 : slot_cnt + 1'b1;
        end else begin
          cycle_nxt = cycle_cnt + 1'b1;
          slot_nxt  = slot_cnt;
        end
      end
      default: state_nxt = DISABLED;
    endcase
  end

  assign frame_nxt = (state_nxt == RUN) && (cycle_nxt == '0) && (slot_nxt == '0);
  assign pop       = (state_nxt == RUN) && (cycle_nxt == '0) &&
                     (slot_nxt == SW'(MY_SLOT)) && !empty;
  assign push      = send_valid;
  assign drop      = send_valid && full && !pop;
  assign send_ready = !full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt      <= '0;
      slot_cnt       <= '0;
      frame_start    <= 1'b0;
      tdma_out       <= '0;
      tdma_out_valid <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      cycle_cnt      <= cycle_nxt;
      slot_cnt       <= slot_nxt;
      frame_start    <= frame_nxt;
      tdma_out       <= pop ? head : '0;
      tdma_out_valid <= pop;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  tdma_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (send_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_tdma_send_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tdma_send_scheduler : directed stimulus, frame-time model, per-cycle compare
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_tdma_send_scheduler;

  localparam int NS = 4;
  localparam int SC = 4;
  localparam int MY = 2;
  localparam int DW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sched_en = 1'b0;
  logic [DW-1:0] send_data = '0;
  logic          send_valid = 1'b0;
  logic          send_ready;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic          overflow_clr = 1'b0;
  logic [DW-1:0] tdma_out;
  logic          tdma_out_valid;
  logic [1:0]    slot_cnt;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  tdma_send_scheduler #(
    .NUM_SLOTS   (NS),
    .SLOT_CYCLES (SC),
    .MY_SLOT     (MY),
    .DATA_W      (DW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sched_en       (sched_en),
    .send_data      (send_data),
    .send_valid     (send_valid),
    .send_ready     (send_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr),
    .tdma_out       (tdma_out),
    .tdma_out_valid (tdma_out_valid),
    .slot_cnt       (slot_cnt),
    .frame_start    (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: time t counts cycles since the scheduler started running.
  logic [DW-1:0] q[$];
  bit            run = 0;
  int            t = 0;
  bit            m_ovf = 0;
  logic [DW-1:0] m_out = '0;
  bit            m_v = 0;
  bit            model_ready = 0;

  always @(posedge clk) begin : model
    int pre;
    bit popped;
    if (!reset_n) begin
      q.delete();
      run = 0; t = 0; m_ovf = 0; m_out = '0; m_v = 0;
      model_ready = 1;
    end else begin
      pre = q.size();
      popped = 0;
      m_out = '0;
      m_v = 0;
      if (sched_en) begin
        if (run) t = t + 1; else t = 0;
        run = 1;
        if (((t / SC) % NS) == MY && (t % SC) == 0 && pre > 0) begin
          m_out = q.pop_front();
          m_v = 1;
          popped = 1;
        end
      end else begin
        run = 0;
        t = 0;
      end
      if (send_valid && (pre < FD || popped)) q.push_back(send_data);
      if (send_valid && pre == FD && !popped) m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
    end
  end

  int            cyc_n = 0;
  int            tx_t[$];
  logic [DW-1:0] tx_d[$];

  always @(negedge clk) begin
    cyc_n++;
    if (model_ready) begin
      check("slot_cnt", 64'(slot_cnt), run ? 64'((t / SC) % NS) : 64'd0);
      check("frame_start", 64'(frame_start), 64'(run && (t % (SC * NS)) == 0));
      check("tdma_out", 64'(tdma_out), 64'(m_out));
      check("tdma_out_valid", 64'(tdma_out_valid), 64'(m_v));
      check("fifo_count", 64'(fifo_count), 64'(q.size()));
      check("send_ready", 64'(send_ready), 64'(q.size() < FD));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (tdma_out_valid === 1'b1) begin
        tx_t.push_back(cyc_n);
        tx_d.push_back(tdma_out);
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    send_valid = 1'b1;
    send_data  = d;
    @(negedge clk);
    send_valid = 1'b0;
  endtask

  initial begin
    // Reset with a push strobe held high.
    reset_n = 1'b0; send_valid = 1'b1; send_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("rst fifo_count", 64'(fifo_count), 64'd0);
    check("rst send_ready", 64'(send_ready), 64'd1);
    check("rst tdma_out_valid", 64'(tdma_out_valid), 64'd0);
    check("rst frame_start", 64'(frame_start), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1; send_valid = 1'b0;
    @(negedge clk);

    // Single word: sent in slot 2 cycle 0, the 9th cycle after enabling.
    push_word(32'hA5A5_0001);
    sched_en = 1'b1;
    @(negedge clk);
    check("en frame_start", 64'(frame_start), 64'd1);
    repeat (8) @(negedge clk);
    check("single tdma_out", 64'(tdma_out), 64'hA5A5_0001);
    check("single valid", 64'(tdma_out_valid), 64'd1);
    check("single slot", 64'(slot_cnt), 64'd2);
    @(negedge clk);
    check("single valid drop", 64'(tdma_out_valid), 64'd0);

    // Ordering and one-per-frame rate.
    tx_t.delete(); tx_d.delete();
    push_word(32'h11); push_word(32'h22); push_word(32'h33);
    repeat (60) @(negedge clk);
    check("order count", 64'(tx_t.size()), 64'd3);
    if (tx_t.size() == 3) begin
      check("order d0", 64'(tx_d[0]), 64'h11);
      check("order d1", 64'(tx_d[1]), 64'h22);
      check("order d2", 64'(tx_d[2]), 64'h33);
      check("order gap1", 64'(tx_t[1] - tx_t[0]), 64'd16);
      check("order gap2", 64'(tx_t[2] - tx_t[1]), 64'd16);
    end

    // Overflow while disabled.
    sched_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push_word(32'h101 + 32'(i));
    check("ovf fifo_count", 64'(fifo_count), 64'd4);
    check("ovf flag", 64'(overflow), 64'd1);
    check("ovf ready", 64'(send_ready), 64'd0);
    send_valid = 1'b1; send_data = 32'h1FF; overflow_clr = 1'b1;
    @(negedge clk);
    send_valid = 1'b0;
    check("ovf set wins", 64'(overflow), 64'd1);
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf cleared", 64'(overflow), 64'd0);
    tx_t.delete(); tx_d.delete();
    sched_en = 1'b1;
    repeat (80) @(negedge clk);
    check("ovf sent count", 64'(tx_t.size()), 64'd4);
    if (tx_d.size() == 4) begin
      check("ovf first", 64'(tx_d[0]), 64'h101);
      check("ovf last", 64'(tx_d[3]), 64'h104);
    end

    // Full FIFO, push on the slot-entry edge.
    sched_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_word(32'h201 + 32'(i));
    check("coll prefill", 64'(fifo_count), 64'd4);
    sched_en = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    send_valid = 1'b1; send_data = 32'h55;
    @(negedge clk);
    send_valid = 1'b0;
    check("coll fifo_count", 64'(fifo_count), 64'd4);
    check("coll overflow", 64'(overflow), 64'd0);
    check("coll tdma_out", 64'(tdma_out), 64'h201);
    check("coll valid", 64'(tdma_out_valid), 64'd1);

    // Reset mid-operation, then disable mid-frame and re-enable.
    sched_en = 1'b0; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst fifo_count", 64'(fifo_count), 64'd0);
    reset_n = 1'b1;
    push_word(32'h77);
    sched_en = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("dis slot1", 64'(slot_cnt), 64'd1);
    tx_t.delete(); tx_d.delete();
    sched_en = 1'b0;
    @(negedge clk);
    check("dis slot0", 64'(slot_cnt), 64'd0);
    repeat (20) @(negedge clk);
    check("dis no tx", 64'(tx_t.size()), 64'd0);
    sched_en = 1'b1;
    @(negedge clk);
    check("reen frame_start", 64'(frame_start), 64'd1);
    repeat (8) @(negedge clk);
    check("reen tdma_out", 64'(tdma_out), 64'h77);
    check("reen valid", 64'(tdma_out_valid), 64'd1);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
